me_pixel_fetch: RTL and testbench
=================================

// Module: me_pixel_fetch
// PURPOSE
//  Upstream feeder for the motion-estimation core. Serves the core's need_cur/need_ref requests
//  from one shared byte-wide pixel memory. Fetches one word per request: 4 current-frame bytes
//  packed into cur_in (32b) or 8 reference-window bytes packed into ref_in (64b), then strobes valid.
//  Replaces the behavioural feeder and connects to the core's cur_in/ref_in/need_cur/need_ref ports.
// PARAMETERS
//  MEM_AW     25        byte-address width of the pixel memory
//  CUR_BASE   0         byte address of the first current-frame byte
//  CUR_BYTES  8294400   current-frame bytes (3840x2160); the cur pointer wraps after this many
//  REF_BASE   8388608   byte address of the first reference byte
//  REF_BYTES  23945760  reference-stream bytes; the ref pointer wraps after this many
// PORTS
//  clk        in   1       clock
//  rst        in   1       reset, asynchronous, active-high
//  need_cur   in   1       core requests one 32b current word
//  need_ref   in   1       core requests one 64b reference word
//  cur_in     out  32      packed current word; byte k in bits [8k+7:8k]
//  cur_valid  out  1       1-cycle strobe: cur_in updated this cycle
//  ref_in     out  64      packed reference word; byte k in bits [8k+7:8k]
//  ref_valid  out  1       1-cycle strobe: ref_in updated this cycle
//  cur_wrap   out  1       1-cycle strobe with cur_valid when the word held the last frame byte
//  ref_wrap   out  1       1-cycle strobe with ref_valid when the word held the last ref byte
//  busy       out  1       high whenever state != IDLE
//  mem_req    out  1       byte read request
//  mem_addr   out  MEM_AW  byte address; valid while mem_req is high
//  mem_gnt    in   1       memory accepted the request this cycle (mem_req & mem_gnt)
//  mem_rdata  in   8       read data
//  mem_rvalid in   1       mem_rdata valid; in order, >=1 cycle after the grant
// BEHAVIOUR
//  - Reset: all outputs 0, both pointers 0, byte counter 0, state IDLE. Async clear; a request in
//    flight is abandoned. Any mem_rvalid arriving while no read is outstanding is ignored.
//  - FSM states: IDLE, CUR, REF.
//    IDLE: need_cur -> CUR. Otherwise need_ref -> REF. Cur has priority when both are high.
//    The choice is made only in IDLE; a word is never interleaved with the other stream.
//    CUR/REF: issue byte reads until 4 (CUR) or 8 (REF) bytes have returned, then -> IDLE.
//  - At most one read outstanding.
//    mem_req is held with a stable mem_addr until mem_gnt.
//    The next mem_req may assert in the same cycle as the previous mem_rvalid.
//  - Address: CUR_BASE+cur_ptr or REF_BASE+ref_ptr.
//    Each pointer increments per granted byte; at CUR_BYTES-1 / REF_BYTES-1 it wraps to 0.
//    A word straddling the wrap continues from byte 0; the wrap strobe fires with that word.
//  - Packing: returned byte n of the word goes into lane n. cur_in/ref_in and the valid strobe
//    are registered on the edge that captures the last byte; the word is visible the next cycle.
//    cur_in/ref_in hold their value until the next completed word of the same stream.
//  - Requests are level-sampled in IDLE only.
//    Deasserting need_* mid-word does not abort: the word completes and strobes.
//    need_* still high in the IDLE cycle after a strobe starts another word.
//  - Latency with mem_gnt tied 1 and 1-cycle read latency:
//    need_cur seen in cycle 0 -> mem_req in cycles 1-4 -> cur_valid in cycle 6.
//    For REF, mem_req in cycles 1-8 -> ref_valid in cycle 10. One IDLE cycle between words.
// TESTING
//  1. mem[0..3]=11,22,33,44; need_cur=1 one cycle, gnt=1, latency 1 -> cur_valid in cycle 6,
//     cur_in=32'h44332211, addr seq 0,1,2,3.
//  2. Both need_cur and need_ref high in IDLE -> cur word completes first.
//     mem_req never targets REF_BASE before cur_valid.
//     REF word at REF_BASE..+7 follows; ref_in=bytes packed little-endian.
//  3. mem_gnt low 3 cycles per request, latency 4 -> mem_addr stable while req pending,
//     one outstanding read; cur_in still correct.
//  4. CUR_BYTES=6 override, two cur words -> second word addresses 4,5,0,1.
//     cur_wrap=1 with the second cur_valid only.
//  5. rst asserted mid-REF after 3 bytes, stale mem_rvalid after release -> outputs 0,
//     stale byte ignored. Next need_ref fetches from REF_BASE+0.
//  6. need_cur dropped after first grant -> word still completes and cur_valid strobes once,
//     then the FSM stays IDLE.

Source files
------------

// File: rtl/me_pixel_fetch.sv
// me_pixel_fetch: feeds the motion-estimation core from one shared byte-wide
// pixel memory. A need_cur request fetches 4 current-frame bytes into cur_in, and
// a need_ref request fetches 8 reference bytes into ref_in. Only one byte read is
// outstanding at a time. The cur and ref pointers wrap independently.
module me_pixel_fetch #(
    parameter int MEM_AW    = 25,
    parameter int CUR_BASE  = 0,
    parameter int CUR_BYTES = 8294400,
    parameter int REF_BASE  = 8388608,
    parameter int REF_BYTES = 23945760
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              need_cur,
    input  logic              need_ref,
    output logic [31:0]       cur_in,
    output logic              cur_valid,
    output logic [63:0]       ref_in,
    output logic              ref_valid,
    output logic              cur_wrap,
    output logic              ref_wrap,
    output logic              busy,
    output logic              mem_req,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_rvalid
);

    localparam logic [MEM_AW-1:0] CUR_BASE_A = MEM_AW'(CUR_BASE);
    localparam logic [MEM_AW-1:0] REF_BASE_A = MEM_AW'(REF_BASE);
    localparam logic [MEM_AW-1:0] CUR_LAST   = MEM_AW'(CUR_BYTES - 1);
    localparam logic [MEM_AW-1:0] REF_LAST   = MEM_AW'(REF_BYTES - 1);

    typedef enum logic [1:0] {IDLE, CUR, REF} state_t;

    state_t            state_q, state_d;
    logic              out_q;                 // one byte read granted, data not yet back
    logic [3:0]        iss_q, ret_q;          // bytes granted / returned in this word
    logic              wrap_q;                // this word touched the last stream byte
    logic [MEM_AW-1:0] cur_ptr_q, ref_ptr_q;
    logic [7:0][7:0]   word_q, word_d;        // assembly buffer, lane n = byte n
    logic [31:0]       cur_in_q;
    logic [63:0]       ref_in_q;
    logic              cur_valid_q, ref_valid_q, cur_wrap_q, ref_wrap_q;

    logic              is_cur, rx, last_rx, grant, at_last, req;
    logic [3:0]        nbytes;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state, request handshake and word assembly
    always_comb begin
        state_d  = state_q;
        is_cur   = (state_q == CUR);
        nbytes   = is_cur ? 4'd4 : 4'd8;
        rx       = out_q & mem_rvalid;        // stray rvalids are ignored
        last_rx  = rx & (ret_q == nbytes - 4'd1);
        // A new read may go out in the same cycle the previous one returns.
        req      = (state_q != IDLE) & (iss_q < nbytes) & (~out_q | mem_rvalid);
        grant    = req & mem_gnt;
        at_last  = is_cur ? (cur_ptr_q == CUR_LAST) : (ref_ptr_q == REF_LAST);
        mem_addr = '0;
        if (state_q == CUR)      mem_addr = CUR_BASE_A + cur_ptr_q;
        else if (state_q == REF) mem_addr = REF_BASE_A + ref_ptr_q;
        word_d = word_q;
        if (rx) word_d[ret_q[2:0]] = mem_rdata;
        case (state_q)
            IDLE: begin
                if (need_cur)      state_d = CUR;
                else if (need_ref) state_d = REF;
            end
            CUR, REF: if (last_rx) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: pointers, counters, outstanding flag, output words and strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q       <= 1'b0;
            iss_q       <= '0;
            ret_q       <= '0;
            wrap_q      <= 1'b0;
            cur_ptr_q   <= '0;
            ref_ptr_q   <= '0;
            word_q      <= '0;
            cur_in_q    <= '0;
            ref_in_q    <= '0;
            cur_valid_q <= 1'b0;
            ref_valid_q <= 1'b0;
            cur_wrap_q  <= 1'b0;
            ref_wrap_q  <= 1'b0;
        end else begin
            word_q <= word_d;
            if (grant)   out_q <= 1'b1;
            else if (rx) out_q <= 1'b0;
            if (state_q == IDLE) begin
                iss_q  <= '0;
                ret_q  <= '0;
                wrap_q <= 1'b0;
            end else begin
                if (grant)           iss_q  <= iss_q + 4'd1;
                if (rx)              ret_q  <= ret_q + 4'd1;
                if (grant & at_last) wrap_q <= 1'b1;
            end
            if (grant & is_cur)  cur_ptr_q <= at_last ? '0 : cur_ptr_q + MEM_AW'(1);
            if (grant & ~is_cur) ref_ptr_q <= at_last ? '0 : ref_ptr_q + MEM_AW'(1);
            cur_valid_q <= last_rx & is_cur;
            ref_valid_q <= last_rx & ~is_cur;
            cur_wrap_q  <= last_rx & is_cur & wrap_q;
            ref_wrap_q  <= last_rx & ~is_cur & wrap_q;
            if (last_rx & is_cur)  cur_in_q <= word_d[3:0];
            if (last_rx & ~is_cur) ref_in_q <= word_d;
        end
    end

    assign mem_req   = req;
    assign busy      = (state_q != IDLE);
    assign cur_in    = cur_in_q;
    assign ref_in    = ref_in_q;
    assign cur_valid = cur_valid_q;
    assign ref_valid = ref_valid_q;
    assign cur_wrap  = cur_wrap_q;
    assign ref_wrap  = ref_wrap_q;

endmodule

// File: tb/tb_me_pixel_fetch.sv
// Directed bench for me_pixel_fetch (CUR_BYTES overridden to 6 so the cur wrap is reachable).
module tb_me_pixel_fetch;
    localparam int AW = 25;
    localparam int RB = 8388608;

    logic          clk = 1'b0, rst = 1'b1, need_cur = 1'b0, need_ref = 1'b0;
    logic [31:0]   cur_in;
    logic [63:0]   ref_in;
    logic          cur_valid, ref_valid, cur_wrap, ref_wrap, busy, mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_gnt, mem_rvalid;
    logic [7:0]    mem_rdata;

    always #5 clk = ~clk;

    me_pixel_fetch #(.MEM_AW(AW), .CUR_BYTES(6)) dut (
        .clk(clk), .rst(rst), .need_cur(need_cur), .need_ref(need_ref),
        .cur_in(cur_in), .cur_valid(cur_valid), .ref_in(ref_in), .ref_valid(ref_valid),
        .cur_wrap(cur_wrap), .ref_wrap(ref_wrap), .busy(busy), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_gnt(mem_gnt), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
    );

    // Memory model: mem[a] = (a+1)*0x11 in the cur area, 0xA0+k at REF_BASE+k.
    int         gnt_dly = 0, lat = 1, wait_cnt = 0, rcnt = 0, cyc = 0;
    logic [7:0] pdata = 8'h00;
    logic       stale_rv = 1'b0;

    function automatic logic [7:0] fdata(input logic [AW-1:0] a);
        if (int'(a) >= RB) return 8'hA0 + a[7:0];
        return (a[7:0] + 8'd1) * 8'h11;
    endfunction

    assign mem_gnt    = (wait_cnt >= gnt_dly);
    assign mem_rvalid = (rcnt == 1) || stale_rv;
    assign mem_rdata  = stale_rv ? 8'hEE : pdata;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_req && mem_gnt) begin
            wait_cnt <= 0;
            rcnt     <= lat;
            pdata    <= fdata(mem_addr);
        end else begin
            if (mem_req) wait_cnt <= wait_cnt + 1;
            if (rcnt > 0) rcnt <= rcnt - 1;
        end
    end

    // Monitor: logs grants, strobes and protocol violations; cleared by rst.
    int            addr_q[$];
    logic          wrap_log[$];
    int            cur_cnt, ref_cnt, cur_cyc, ref_cyc, first_gnt_cyc, first_ref_cyc;
    int            rv_total, unstable, viol, ost;
    logic [31:0]   cur_word;
    logic [63:0]   ref_word;
    logic          prev_pend;
    logic [AW-1:0] prev_addr;

    always @(negedge clk) begin
        if (rst) begin
            addr_q.delete(); wrap_log.delete();
            cur_cnt = 0; ref_cnt = 0; cur_cyc = 0; ref_cyc = 0;
            first_gnt_cyc = -1; first_ref_cyc = -1;
            rv_total = 0; unstable = 0; viol = 0; ost = 0; prev_pend = 1'b0;
        end else begin
            if (prev_pend && (!mem_req || mem_addr != prev_addr)) unstable++;
            if (mem_req && mem_gnt) begin
                if (ost > 0 && !mem_rvalid) viol++;
                if (addr_q.size() == 0) first_gnt_cyc = cyc;
                if (int'(mem_addr) >= RB && first_ref_cyc < 0) first_ref_cyc = cyc;
                addr_q.push_back(int'(mem_addr));
            end
            if (mem_rvalid) rv_total++;
            ost = ost + ((mem_req && mem_gnt) ? 1 : 0) - ((mem_rvalid && ost > 0) ? 1 : 0);
            prev_pend = mem_req && !mem_gnt;
            prev_addr = mem_addr;
            if (cur_valid) begin cur_cnt++; cur_cyc = cyc; cur_word = cur_in; wrap_log.push_back(cur_wrap); end
            if (ref_valid) begin ref_cnt++; ref_cyc = cyc; ref_word = ref_in; end
        end
    end

    int errors = 0, checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic do_rst();
        rst = 1'b1; tick(2); rst = 1'b0; tick(2);
    endtask

    task automatic wait_cur(input int n, input string tag);
        int k = 0;
        while (cur_cnt < n && k < 400) begin tick(1); k++; end
        chk(tag, 64'(cur_cnt >= n), 64'd1);
    endtask

    task automatic wait_ref(input int n, input string tag);
        int k = 0;
        while (ref_cnt < n && k < 400) begin tick(1); k++; end
        chk(tag, 64'(ref_cnt >= n), 64'd1);
    endtask

    task automatic chk_addrs(input string tag, input int exp[$]);
        chk({tag, "_cnt"}, 64'(addr_q.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size() && i < addr_q.size(); i++)
            chk($sformatf("%s_%0d", tag, i), 64'(addr_q[i]), 64'(exp[i]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, k;
        // Reset state
        tick(2);
        chk("rst_cur_in", 64'(cur_in), 64'd0);
        chk("rst_ref_in", ref_in, 64'd0);
        chk("rst_flags", 64'({cur_valid, ref_valid, cur_wrap, ref_wrap, busy, mem_req}), 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        rst = 1'b0; tick(2);

        // 1: single cur word, gnt tied, latency 1
        c0 = cyc; need_cur = 1'b1; tick(1); need_cur = 1'b0;
        wait_cur(1, "t1_wait");
        chk("t1_latency", 64'(cur_cyc - c0), 64'd6);
        chk("t1_first_req", 64'(first_gnt_cyc - c0), 64'd1);
        chk("t1_word", 64'(cur_word), 64'h44332211);
        chk("t1_wrap", 64'(wrap_log[0]), 64'd0);
        chk_addrs("t1_addr", '{0, 1, 2, 3});
        tick(5);
        chk("t1_once", 64'(cur_cnt), 64'd1);
        chk("t1_idle", 64'(busy), 64'd0);

        // 2: both requests together, cur first then ref
        do_rst();
        need_cur = 1'b1; need_ref = 1'b1; tick(1); need_cur = 1'b0;
        wait_cur(1, "t2_wait_cur");
        tick(1); need_ref = 1'b0;
        wait_ref(1, "t2_wait_ref");
        chk("t2_cur_word", 64'(cur_word), 64'h44332211);
        chk("t2_ref_after_cur", 64'(first_ref_cyc - cur_cyc), 64'd1);
        chk("t2_ref_latency", 64'(ref_cyc - cur_cyc), 64'd10);
        chk("t2_ref_word", ref_word, 64'hA7A6A5A4A3A2A1A0);
        chk_addrs("t2_addr", '{0, 1, 2, 3, RB, RB+1, RB+2, RB+3, RB+4, RB+5, RB+6, RB+7});

        // 3: grant held off 3 cycles, latency 4
        do_rst();
        gnt_dly = 3; lat = 4;
        need_cur = 1'b1; tick(1); need_cur = 1'b0;
        wait_cur(1, "t3_wait");
        chk("t3_word", 64'(cur_word), 64'h44332211);
        chk("t3_addr_stable", 64'(unstable), 64'd0);
        chk("t3_one_outstanding", 64'(viol), 64'd0);
        chk_addrs("t3_addr", '{0, 1, 2, 3});
        gnt_dly = 0; lat = 1;

        // 4: cur pointer wraps inside the second word
        do_rst();
        need_cur = 1'b1; tick(1); need_cur = 1'b0;
        wait_cur(1, "t4_wait1");
        need_cur = 1'b1; tick(1); need_cur = 1'b0;
        wait_cur(2, "t4_wait2");
        chk("t4_word2", 64'(cur_word), 64'h22116655);
        chk("t4_wrap_cnt", 64'(wrap_log.size()), 64'd2);
        if (wrap_log.size() == 2) begin
            chk("t4_wrap_first", 64'(wrap_log[0]), 64'd0);
            chk("t4_wrap_second", 64'(wrap_log[1]), 64'd1);
        end
        chk_addrs("t4_addr", '{0, 1, 2, 3, 4, 5, 0, 1});

        // 5: reset in the middle of a ref word, stale rvalid afterwards
        do_rst();
        lat = 4;
        need_ref = 1'b1; tick(1); need_ref = 1'b0;
        k = 0;
        while (rv_total < 3 && k < 100) begin tick(1); k++; end
        chk("t5_wait_bytes", 64'(rv_total >= 3), 64'd1);
        tick(1);
        rst = 1'b1; tick(1);
        chk("t5_rst_outputs", 64'({cur_valid, ref_valid, cur_wrap, ref_wrap, busy, mem_req}), 64'd0);
        chk("t5_rst_ref_in", ref_in, 64'd0);
        chk("t5_rst_addr", 64'(mem_addr), 64'd0);
        rst = 1'b0; stale_rv = 1'b1; tick(1); stale_rv = 1'b0;
        tick(8);
        chk("t5_no_strobe", 64'(ref_cnt + cur_cnt), 64'd0);
        chk("t5_idle", 64'({busy, mem_req}), 64'd0);
        need_ref = 1'b1; tick(1); need_ref = 1'b0;
        wait_ref(1, "t5_wait_ref");
        chk("t5_ref_word", ref_word, 64'hA7A6A5A4A3A2A1A0);
        chk_addrs("t5_addr", '{RB, RB+1, RB+2, RB+3, RB+4, RB+5, RB+6, RB+7});
        lat = 1;

        // 6: need_cur dropped after the first grant
        do_rst();
        need_cur = 1'b1;
        k = 0;
        while (addr_q.size() < 1 && k < 20) begin tick(1); k++; end
        chk("t6_first_grant", 64'(addr_q.size()), 64'd1);
        need_cur = 1'b0;
        wait_cur(1, "t6_wait");
        tick(10);
        chk("t6_once", 64'(cur_cnt), 64'd1);
        chk("t6_idle", 64'(busy), 64'd0);
        chk("t6_word", 64'(cur_word), 64'h44332211);
        chk("t6_reads", 64'(addr_q.size()), 64'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
